serial_frame_rx: RTL and testbench
==================================

// Module: serial_frame_rx
// PURPOSE
//   Serial-to-parallel frame receiver; consumes the 1-bit registered stream produced by the D-flip-flop
//   input stage and assembles it into DATA_W-bit words.
//   Frame format (one bit per bit_en cycle): start bit (0), DATA_W data bits LSB first,
//   optional even-parity bit, stop bit (1).
//   Words go downstream over a valid/ready handshake; parity, framing and overrun faults are flagged.
// PARAMETERS
//   DATA_W     8   data bits per frame (legal 1..16)
//   PARITY_EN  1   1: even-parity bit follows data; 0: no parity bit, parity_err tied 0
// PORTS
//   clk         in   1        single clock, all logic on posedge
//   rst         in   1        synchronous, active-high reset
//   bit_en      in   1        din holds a valid bit this cycle; sampled only when 1
//   din         in   1        serial bit from upstream D flip-flop
//   out_data    out  DATA_W   received word
//   out_valid   out  1        out_data/parity_err valid
//   out_ready   in   1        downstream accepts word when out_valid & out_ready at posedge
//   parity_err  out  1        parity mismatch for word in out_data; qualified by out_valid
//   frame_err   out  1        1-cycle pulse: stop bit sampled as 0
//   overrun     out  1        1-cycle pulse: good frame dropped, output still occupied
//   busy        out  1        1 when state != IDLE
// BEHAVIOUR
//   Reset: rst=1 at posedge -> state IDLE, bit_cnt 0, shift reg 0, out_data 0, out_valid 0,
//     parity_err 0, frame_err 0, overrun 0, busy 0. Overrides everything, incl. mid-frame and pending word.
//   bit_en=0: state, counters and shift reg hold; din ignored. Handshake still operates.
//   FSM states: IDLE, DATA, PARITY, STOP.
//     IDLE:   bit_en & din=0 -> DATA, bit_cnt=0. din=1 -> stay (line idle).
//     DATA:   each bit_en: shift[bit_cnt]=din, bit_cnt++. After bit DATA_W-1 -> PARITY if PARITY_EN, else STOP.
//     PARITY: bit_en: capture p; perr = ^shift ^ p (even parity; 1 = error) -> STOP.
//     STOP:   bit_en & din=1 -> deliver word, -> IDLE. bit_en & din=0 -> frame_err=1 for 1 cycle,
//             word discarded, -> IDLE (next 0 seen in IDLE starts a new frame).
//   Deliver (posedge sampling a good stop bit):
//     - out_valid=0, or out_valid & out_ready same edge: out_data<=shift, parity_err<=perr, out_valid<=1.
//       Latency: out_valid high right after the stop-bit sampling edge.
//     - out_valid & !out_ready: new word dropped, out_data/parity_err unchanged, overrun=1 for 1 cycle.
//   Handshake: out_valid & out_ready at posedge -> out_valid<=0 unless a new word loads same edge (then stays 1).
//     out_data/parity_err stable while out_valid & !out_ready. out_valid never drops without acceptance or rst.
//   bit_cnt width = clog2(DATA_W)+1; no wrap within a frame. frame_err and overrun never assert together.
// TESTING
//   1 rst=1 for 2 cycles mid-DATA with out_valid=1 -> all outputs 0, busy=0, next frame received normally.
//   2 DATA_W=8, PARITY_EN=1, bit_en=1 always, out_ready=1; bits 0,1,0,1,0,0,1,0,1,0,1 (0xA5, p=0, stop) ->
//     out_valid=1 one cycle after stop edge, out_data=0xA5, parity_err=0.
//   3 As 2 with parity bit 1 -> out_data=0xA5, parity_err=1, frame_err=0.
//   4 As 2 with stop bit 0 -> frame_err one-cycle pulse, out_valid stays 0, busy=0 next cycle.
//   5 out_ready=0; frames 0x3C then 0xC3 -> out_data stays 0x3C, overrun pulses at second stop;
//     then out_ready=1 -> 0x3C accepted, out_valid=0.
//   6 bit_en high every 3rd cycle, frame 0x5A with out_ready pulsed on the stop edge while prior word
//     valid -> 0x5A loads same edge, out_valid stays 1, no overrun.

Source files
------------

// File: rtl/serial_frame_rx.sv
// serial_frame_rx: serial-to-parallel frame receiver.
// Frame: start bit (0), DATA_W data bits LSB first, optional even-parity bit, stop bit (1).
// Received words leave over a valid/ready handshake. Parity, framing and overrun faults are flagged.
module serial_frame_rx #(
    parameter int DATA_W    = 8,
    parameter int PARITY_EN = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              bit_en,
    input  logic              din,
    output logic [DATA_W-1:0] out_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic              parity_err,
    output logic              frame_err,
    output logic              overrun,
    output logic              busy
);

    localparam int CNT_W = $clog2(DATA_W) + 1;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        DATA   = 2'd1,
        PARITY = 2'd2,
        STOP   = 2'd3
    } state_t;

    state_t             state_q,      state_d;
    logic [CNT_W-1:0]   bit_cnt_q,    bit_cnt_d;
    logic [DATA_W-1:0]  shift_q,      shift_d;
    logic               perr_q,       perr_d;
    logic [DATA_W-1:0]  out_data_q,   out_data_d;
    logic               out_valid_q,  out_valid_d;
    logic               parity_err_q, parity_err_d;
    logic               frame_err_q,  frame_err_d;
    logic               overrun_q,    overrun_d;
    logic               busy_q,       busy_d;

    logic               last_bit_s;
    logic               good_stop_s;
    logic               accept_s;

    // Frame sequencing: next state, bit counter, shift register and running parity result.
    always_comb begin
        state_d    = state_q;
        bit_cnt_d  = bit_cnt_q;
        shift_d    = shift_q;
        perr_d     = perr_q;
        last_bit_s = (bit_cnt_q == CNT_W'(DATA_W - 1));
        if (bit_en) begin
            case (state_q)
                IDLE: begin
                    if (!din) begin
                        state_d   = DATA;
                        bit_cnt_d = {CNT_W{1'b0}};
                        perr_d    = 1'b0;
                    end else begin
                        state_d   = IDLE;
                    end
                end
                DATA: begin
                    // Write din into the slot selected by bit_cnt without a mismatched-width index.
                    for (int i = 0; i < DATA_W; i++) begin
                        if (bit_cnt_q == CNT_W'(i)) begin
                            shift_d[i] = din;
                        end else begin
                            shift_d[i] = shift_q[i];
                        end
                    end
                    bit_cnt_d = bit_cnt_q + CNT_W'(1);
                    if (last_bit_s) begin
                        state_d = (PARITY_EN != 0) ? PARITY : STOP;
                    end else begin
                        state_d = DATA;
                    end
                end
                PARITY: begin
                    // Even parity: XOR of data and parity bit must be 0, so a 1 flags an error.
                    perr_d  = (^shift_q) ^ din;
                    state_d = STOP;
                end
                STOP: begin
                    state_d = IDLE;
                end
                default: begin
                    state_d = IDLE;
                end
            endcase
        end else begin
            state_d = state_q;
        end
    end

    // Output side: word delivery, handshake retirement and one-cycle fault pulses.
    always_comb begin
        out_data_d   = out_data_q;
        out_valid_d  = out_valid_q;
        parity_err_d = parity_err_q;
        frame_err_d  = 1'b0;
        overrun_d    = 1'b0;
        accept_s     = out_valid_q & out_ready;
        good_stop_s  = bit_en & din & (state_q == STOP);
        if (good_stop_s) begin
            // A word being accepted on this same edge frees the slot for the new one.
            if (!out_valid_q || out_ready) begin
                out_data_d   = shift_q;
                parity_err_d = (PARITY_EN != 0) ? perr_q : 1'b0;
                out_valid_d  = 1'b1;
            end else begin
                overrun_d    = 1'b1;
            end
        end else if (bit_en && !din && (state_q == STOP)) begin
            frame_err_d = 1'b1;
            if (accept_s) begin
                out_valid_d = 1'b0;
            end else begin
                out_valid_d = out_valid_q;
            end
        end else if (accept_s) begin
            out_valid_d = 1'b0;
        end else begin
            out_valid_d = out_valid_q;
        end
        busy_d = (state_d != IDLE);
    end

    // State and output registers with synchronous reset overriding any frame or pending word.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= IDLE;
            bit_cnt_q    <= {CNT_W{1'b0}};
            shift_q      <= {DATA_W{1'b0}};
            perr_q       <= 1'b0;
            out_data_q   <= {DATA_W{1'b0}};
            out_valid_q  <= 1'b0;
            parity_err_q <= 1'b0;
            frame_err_q  <= 1'b0;
            overrun_q    <= 1'b0;
            busy_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            bit_cnt_q    <= bit_cnt_d;
            shift_q      <= shift_d;
            perr_q       <= perr_d;
            out_data_q   <= out_data_d;
            out_valid_q  <= out_valid_d;
            parity_err_q <= parity_err_d;
            frame_err_q  <= frame_err_d;
            overrun_q    <= overrun_d;
            busy_q       <= busy_d;
        end
    end

    assign out_data   = out_data_q;
    assign out_valid  = out_valid_q;
    assign parity_err = parity_err_q;
    assign frame_err  = frame_err_q;
    assign overrun    = overrun_q;
    assign busy       = busy_q;

endmodule

// File: tb/tb_serial_frame_rx.sv
// Directed testbench for serial_frame_rx (DATA_W=8, PARITY_EN=1).
module tb_serial_frame_rx;

    logic       clk;
    logic       rst;
    logic       bit_en;
    logic       din;
    logic [7:0] out_data;
    logic       out_valid;
    logic       out_ready;
    logic       parity_err;
    logic       frame_err;
    logic       overrun;
    logic       busy;

    int checks = 0;
    int errors = 0;

    serial_frame_rx #(.DATA_W(8), .PARITY_EN(1)) dut (
        .clk        (clk),
        .rst        (rst),
        .bit_en     (bit_en),
        .din        (din),
        .out_data   (out_data),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .parity_err (parity_err),
        .frame_err  (frame_err),
        .overrun    (overrun),
        .busy       (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance one clock; outputs are sampled 1 time unit after the edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic send_bit(input logic b, input int gap);
        bit_en = 1'b1;
        din    = b;
        tick();
        bit_en = 1'b0;
        repeat (gap) tick();
    endtask

    // Start, 8 data bits LSB first, parity, stop. Returns right after the stop-bit edge.
    task automatic send_frame(input logic [7:0] data, input logic p, input logic stop,
                              input int gap, input logic pulse_ready);
        send_bit(1'b0, gap);
        for (int i = 0; i < 8; i++) send_bit(data[i], gap);
        send_bit(p, gap);
        if (pulse_ready) out_ready = 1'b1;
        bit_en = 1'b1;
        din    = stop;
        tick();
        if (pulse_ready) out_ready = 1'b0;
        bit_en = 1'b0;
        din    = 1'b1;
    endtask

    initial begin
        rst       = 1'b1;
        bit_en    = 1'b0;
        din       = 1'b1;
        out_ready = 1'b0;
        tick();
        tick();
        chk("reset_valid", 16'(out_valid), 16'h0);
        chk("reset_data",  16'(out_data),  16'h0);
        chk("reset_busy",  16'(busy),      16'h0);
        chk("reset_ferr",  16'(frame_err), 16'h0);
        rst = 1'b0;
        tick();

        // Reset mid-frame with a pending word.
        send_frame(8'hA5, 1'b0, 1'b1, 0, 1'b0);
        chk("t1_pending_valid", 16'(out_valid), 16'h1);
        send_bit(1'b0, 0);
        send_bit(1'b1, 0);
        send_bit(1'b0, 0);
        chk("t1_mid_busy", 16'(busy), 16'h1);
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        chk("t1_rst_valid", 16'(out_valid),  16'h0);
        chk("t1_rst_data",  16'(out_data),   16'h0);
        chk("t1_rst_perr",  16'(parity_err), 16'h0);
        chk("t1_rst_ovr",   16'(overrun),    16'h0);
        chk("t1_rst_busy",  16'(busy),       16'h0);
        out_ready = 1'b1;
        send_frame(8'h3C, 1'b0, 1'b1, 0, 1'b0);
        chk("t1_next_valid", 16'(out_valid), 16'h1);
        chk("t1_next_data",  16'(out_data),  16'h3C);

        // Good frame 0xA5, even parity bit 0.
        send_frame(8'hA5, 1'b0, 1'b1, 0, 1'b0);
        chk("t2_valid", 16'(out_valid),  16'h1);
        chk("t2_data",  16'(out_data),   16'hA5);
        chk("t2_perr",  16'(parity_err), 16'h0);
        chk("t2_busy",  16'(busy),       16'h0);

        // Wrong parity bit.
        send_frame(8'hA5, 1'b1, 1'b1, 0, 1'b0);
        chk("t3_data", 16'(out_data),   16'hA5);
        chk("t3_perr", 16'(parity_err), 16'h1);
        chk("t3_ferr", 16'(frame_err),  16'h0);
        tick();
        chk("t3_accepted", 16'(out_valid), 16'h0);

        // Stop bit 0: framing error, word discarded.
        send_frame(8'hA5, 1'b0, 1'b0, 0, 1'b0);
        chk("t4_ferr",  16'(frame_err), 16'h1);
        chk("t4_valid", 16'(out_valid), 16'h0);
        chk("t4_busy",  16'(busy),      16'h0);
        tick();
        chk("t4_ferr_pulse", 16'(frame_err), 16'h0);

        // Overrun with output held.
        out_ready = 1'b0;
        send_frame(8'h3C, 1'b0, 1'b1, 0, 1'b0);
        chk("t5_first_data",  16'(out_data),  16'h3C);
        chk("t5_first_valid", 16'(out_valid), 16'h1);
        chk("t5_first_ovr",   16'(overrun),   16'h0);
        send_frame(8'hC3, 1'b0, 1'b1, 0, 1'b0);
        chk("t5_ovr",       16'(overrun),   16'h1);
        chk("t5_hold_data", 16'(out_data),  16'h3C);
        chk("t5_hold_vld",  16'(out_valid), 16'h1);
        chk("t5_no_ferr",   16'(frame_err), 16'h0);
        tick();
        chk("t5_ovr_pulse", 16'(overrun),   16'h0);
        chk("t5_still_vld", 16'(out_valid), 16'h1);
        out_ready = 1'b1;
        tick();
        chk("t5_accepted", 16'(out_valid), 16'h0);

        // Sparse bit_en, ready pulsed exactly on the stop edge.
        out_ready = 1'b0;
        send_frame(8'h11, 1'b0, 1'b1, 0, 1'b0);
        chk("t6_prior_data", 16'(out_data), 16'h11);
        send_bit(1'b0, 2);
        chk("t6_gap_busy", 16'(busy), 16'h1);
        for (int i = 0; i < 8; i++) send_bit(bit'((8'h5A >> i) & 8'h01), 2);
        send_bit(1'b0, 2);
        out_ready = 1'b1;
        bit_en    = 1'b1;
        din       = 1'b1;
        tick();
        out_ready = 1'b0;
        bit_en    = 1'b0;
        chk("t6_valid", 16'(out_valid), 16'h1);
        chk("t6_data",  16'(out_data),  16'h5A);
        chk("t6_ovr",   16'(overrun),   16'h0);
        chk("t6_perr",  16'(parity_err), 16'h0);
        tick();
        chk("t6_hold_valid", 16'(out_valid), 16'h1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
